ysyx_23060072_mem_arbiter: RTL and testbench
============================================

# ysyx_23060072_mem_arbiter

Shares the core's single memory port between instruction fetch and the load/store stage. Accepts one request at a time from either requester, drives it onto the memory bus, and routes the response back to its owner. Sits between the IF and LSU stages and the external memory, with one outstanding transaction at most. Also drops fetch responses invalidated by a pipeline flush.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline clean/redirect; kills in-flight and same-cycle fetch
- if_req_i  in  1  fetch request; held with if_addr_i until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch data valid, single-cycle pulse
- if_rdata_o  out  DATA_W  fetch data
- lsu_req_i  in  1  data request; held with all lsu_* fields until lsu_gnt_o
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_wmask_i  in  DATA_W/8  byte enables for store
- lsu_addr_i  in  ADDR_W  data address
- lsu_wdata_i  in  DATA_W  store data
- lsu_gnt_o  out  1  data request accepted this cycle
- lsu_rvalid_o  out  1  load data / store ack valid, single-cycle pulse
- lsu_rdata_o  out  DATA_W  load data (don't-care for stores)
- mem_req_o  out  1  memory request, held until mem_gnt_i
- mem_we_o, mem_wmask_o, mem_addr_o, mem_wdata_o  out  1/DATA_W/8/ADDR_W/DATA_W  registered request fields
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_W  memory response data

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: pick a winner among if_req_i (masked by flush_i) and lsu_req_i. Assert the winner's gnt_o combinationally. On the edge, latch the request fields and the owner, then go to REQ. No request: stay in IDLE.
- Default priority is fixed, LSU over IF.
- REQ: mem_req_o = 1 and fields come from registers. On mem_gnt_i go to WAIT.
- WAIT: on mem_rvalid_i, drive the owner's rvalid_o = 1 and pass mem_rdata_i to its rdata_o combinationally in the same cycle, then go to IDLE.
- A new request can be accepted only in IDLE. The minimum issue interval is 3 cycles with zero-wait memory.
- Drop flag: set when flush_i = 1 while the owner is IF and the state is REQ or WAIT. The transaction still completes on the bus, but if_rvalid_o is suppressed. The flag clears on return to IDLE.
- flush_i never affects LSU transactions.
- Non-owner rvalid_o is always 0. rdata_o of a non-owner is don't-care; the implementation drives 0.
- mem_rvalid_i outside WAIT is ignored.

## Timing
- Reset values:
  - state = IDLE, drop = 0, all registered mem_* = 0, mem_req_o = 0.
  - All gnt_o and rvalid_o = 0.
  - Round-robin pointer = "IF last served".
- Accept in cycle n → mem_req_o high from n+1.
- mem_gnt_i in cycle m → WAIT from m+1.
- mem_rvalid_i in cycle k → owner's rvalid_o in k (0-cycle pass-through) → IDLE at k+1.
- Simultaneous mem_gnt_i and mem_rvalid_i in REQ: the rvalid is ignored. Memory must not respond in its grant cycle.
- flush_i and if_req_i in the same IDLE cycle: IF is not granted, and LSU may be granted.
- Reset mid-transaction: returns to IDLE immediately and drops the transaction with no response. The memory side must be reset together with the arbiter.

## Configuration
- YSYX_23060072_ARB_RR_EN defined: round-robin. On a simultaneous request, the requester not served last wins, and the pointer updates on every grant.
- Not defined: fixed LSU-over-IF priority, and no pointer register is built.

## Test plan
- Single fetch, addr 0x8000_0000, memory grants the next cycle and returns 0x0000_0513 two cycles later:
  - if_gnt_o at cycle 0; mem_req_o at cycle 1; if_rvalid_o with 0x0000_0513 at cycle 4; back in IDLE at cycle 5.
- Store, addr 0x8000_1004, wdata 0xDEADBEEF, wmask 0xF:
  - mem_we_o = 1 and fields match exactly.
  - lsu_rvalid_o pulses once; if_rvalid_o stays 0.
- IF and LSU request in the same IDLE cycle, repeated twice:
  - Without the macro, LSU wins both times and IF is granted after them.
  - With YSYX_23060072_ARB_RR_EN, the winners are LSU then IF.
- Fetch in WAIT with flush_i pulsed for 1 cycle, then mem_rvalid_i:
  - if_rvalid_o stays 0 and the FSM returns to IDLE.
  - The next fetch at 0x8000_0010 completes normally.
- LSU load with flush_i high during WAIT:
  - lsu_rvalid_o still pulses with mem_rdata_i = 0x1234_5678.
- rst_n asserted low while in WAIT:
  - All outputs go to 0 asynchronously and the FSM is in IDLE.
  - A later mem_rvalid_i produces no rvalid_o.

Source files
------------

// File: rtl/ysyx_23060072_mem_arbiter.sv
// ysyx_23060072_mem_arbiter
// Shares one memory port between instruction fetch (IF) and load/store (LSU).
// One transaction in flight at most: IDLE -> REQ -> WAIT -> IDLE.
// Fetch responses invalidated by flush_i are completed on the bus but not
// returned to IF.
// Optional feature: define YSYX_23060072_ARB_RR_EN for round-robin
// arbitration. Without it, LSU has fixed priority over IF.
module ysyx_23060072_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [DATA_W/8-1:0] lsu_wmask_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_lsu_q, owner_lsu_d;   // 1 = LSU owns the transaction
  logic                  drop_q, drop_d;             // fetch response must be discarded
  logic                  mem_we_q, mem_we_d;
  logic [DATA_W/8-1:0]   mem_wmask_q, mem_wmask_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

  logic                  if_eff_s;                   // fetch request surviving flush
  logic                  pick_if_s;
  logic                  pick_lsu_s;
  logic                  rsp_s;                      // accepted memory response this cycle

  assign if_eff_s = if_req_i & ~flush_i;

`ifdef YSYX_23060072_ARB_RR_EN
  logic last_lsu_q, last_lsu_d;                      // 1 = LSU was served last

  // Winner selection: on contention, the requester not served last wins
  always_comb begin
    pick_if_s  = 1'b0;
    pick_lsu_s = 1'b0;
    if (state_q == S_IDLE) begin
      if (lsu_req_i && if_eff_s) begin
        pick_if_s  = last_lsu_q;
        pick_lsu_s = ~last_lsu_q;
      end else begin
        pick_if_s  = if_eff_s;
        pick_lsu_s = lsu_req_i;
      end
    end else begin
      pick_if_s  = 1'b0;
      pick_lsu_s = 1'b0;
    end
  end

  // Pointer next value: follows every grant
  always_comb begin
    last_lsu_d = last_lsu_q;
    if (pick_lsu_s) begin
      last_lsu_d = 1'b1;
    end else if (pick_if_s) begin
      last_lsu_d = 1'b0;
    end else begin
      last_lsu_d = last_lsu_q;
    end
  end

  // Pointer register; reset means "IF served last" so LSU wins first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lsu_q <= 1'b0;
    end else begin
      last_lsu_q <= last_lsu_d;
    end
  end
`else
  // Winner selection: fixed LSU-over-IF priority
  always_comb begin
    pick_if_s  = 1'b0;
    pick_lsu_s = 1'b0;
    if (state_q == S_IDLE) begin
      pick_lsu_s = lsu_req_i;
      pick_if_s  = if_eff_s & ~lsu_req_i;
    end else begin
      pick_if_s  = 1'b0;
      pick_lsu_s = 1'b0;
    end
  end
`endif

  // Next-state logic: accept in IDLE, hand off on grant, retire on response
  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    drop_d      = drop_q;
    mem_we_d    = mem_we_q;
    mem_wmask_d = mem_wmask_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (pick_lsu_s) begin
          state_d     = S_REQ;
          owner_lsu_d = 1'b1;
          mem_we_d    = lsu_we_i;
          mem_wmask_d = lsu_wmask_i;
          mem_addr_d  = lsu_addr_i;
          mem_wdata_d = lsu_wdata_i;
        end else if (pick_if_s) begin
          state_d     = S_REQ;
          owner_lsu_d = 1'b0;
          mem_we_d    = 1'b0;
          mem_wmask_d = {(DATA_W/8){1'b0}};
          mem_addr_d  = if_addr_i;
          mem_wdata_d = {DATA_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (flush_i && !owner_lsu_q) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        // A response in the grant cycle is ignored: only WAIT looks at rvalid.
        if (mem_gnt_i) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
        end else if (flush_i && !owner_lsu_q) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  // State and request-field registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_lsu_q <= 1'b0;
      drop_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wmask_q <= {(DATA_W/8){1'b0}};
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      drop_q      <= drop_d;
      mem_we_q    <= mem_we_d;
      mem_wmask_q <= mem_wmask_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // A flush arriving in the response cycle itself also kills the fetch data.
  assign rsp_s        = (state_q == S_WAIT) & mem_rvalid_i;
  assign if_gnt_o     = pick_if_s;
  assign lsu_gnt_o    = pick_lsu_s;
  assign lsu_rvalid_o = rsp_s & owner_lsu_q;
  assign if_rvalid_o  = rsp_s & ~owner_lsu_q & ~drop_q & ~flush_i;
  assign if_rdata_o   = if_rvalid_o  ? mem_rdata_i : {DATA_W{1'b0}};
  assign lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : {DATA_W{1'b0}};

  assign mem_req_o    = (state_q == S_REQ);
  assign mem_we_o     = mem_we_q;
  assign mem_wmask_o  = mem_wmask_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_ysyx_23060072_mem_arbiter.sv
// Directed bench for ysyx_23060072_mem_arbiter. Inputs change 1 ns after the
// rising edge; outputs are compared 1 ns later, well clear of the next edge.
// Expected arbitration order follows YSYX_23060072_ARB_RR_EN when defined.
module tb_ysyx_23060072_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [3:0]  lsu_wmask_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int vectors = 0;
  int miscompares = 0;

  ysyx_23060072_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_wmask_i(lsu_wmask_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_wmask_o(mem_wmask_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: from the accept cycle, grant in the next cycle and present
  // the response the cycle after; returns in the response cycle.
  task automatic serve(input bit clr_if, input bit clr_lsu, input logic [31:0] d);
    tick();
    if (clr_if)  if_req_i  = 1'b0;
    if (clr_lsu) lsu_req_i = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = d;
    #1;
  endtask

  task automatic end_rsp();
    tick();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; if_req_i = 1'b0; if_addr_i = 32'h0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_wmask_i = 4'h0; lsu_addr_i = 32'h0;
    lsu_wdata_i = 32'h0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    #12;
    vectors++;
    if ({mem_req_o, mem_we_o, mem_wmask_o, mem_addr_o, mem_wdata_o} !== 70'h0) begin
      miscompares++; $display("FAIL reset_mem got req=%b we=%b addr=%h expected all 0", mem_req_o, mem_we_o, mem_addr_o);
    end
    vectors++;
    if ({if_gnt_o, lsu_gnt_o, if_rvalid_o, lsu_rvalid_o} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_hs got gnt/rvalid=%b%b%b%b expected 0000", if_gnt_o, lsu_gnt_o, if_rvalid_o, lsu_rvalid_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0000;
    #1;
    vectors++;
    if (if_gnt_o !== 1'b1 || lsu_gnt_o !== 1'b0) begin
      miscompares++; $display("FAIL fetch_gnt got if=%b lsu=%b expected 1 0", if_gnt_o, lsu_gnt_o);
    end
    tick();                                   // cycle 1
    if_req_i = 1'b0; if_addr_i = 32'h0;
    #1;
    vectors++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8000_0000 || mem_we_o !== 1'b0) begin
      miscompares++; $display("FAIL fetch_req got req=%b addr=%h we=%b expected 1 80000000 0", mem_req_o, mem_addr_o, mem_we_o);
    end
    tick();                                   // cycle 2: memory grants
    mem_gnt_i = 1'b1;
    tick();                                   // cycle 3: WAIT
    mem_gnt_i = 1'b0;
    #1;
    vectors++;
    if (mem_req_o !== 1'b0 || if_rvalid_o !== 1'b0) begin
      miscompares++; $display("FAIL fetch_wait got req=%b rvalid=%b expected 0 0", mem_req_o, if_rvalid_o);
    end
    tick();                                   // cycle 4: response
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0513;
    #1;
    vectors++;
    if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h0000_0513 || lsu_rvalid_o !== 1'b0) begin
      miscompares++; $display("FAIL fetch_rsp got rvalid=%b data=%h lsu_rvalid=%b expected 1 00000513 0", if_rvalid_o, if_rdata_o, lsu_rvalid_o);
    end
    tick();                                   // cycle 5: IDLE again
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    if_req_i = 1'b1;
    #1;
    vectors++;
    if (if_gnt_o !== 1'b1 || if_rvalid_o !== 1'b0) begin
      miscompares++; $display("FAIL fetch_idle got gnt=%b rvalid=%b expected 1 0", if_gnt_o, if_rvalid_o);
    end
    if_req_i = 1'b0;                          // probe only, withdraw before the edge
    tick();
  endtask

  task automatic test_store();
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h8000_1004;
    lsu_wdata_i = 32'hDEAD_BEEF; lsu_wmask_i = 4'hF;
    #1;
    vectors++;
    if (lsu_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
      miscompares++; $display("FAIL store_gnt got lsu=%b if=%b expected 1 0", lsu_gnt_o, if_gnt_o);
    end
    tick();
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0; lsu_wmask_i = 4'h0;
    #1;
    vectors++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h8000_1004 ||
        mem_wdata_o !== 32'hDEAD_BEEF || mem_wmask_o !== 4'hF) begin
      miscompares++; $display("FAIL store_fields got req=%b we=%b addr=%h wdata=%h wmask=%h expected 1 1 80001004 deadbeef f",
                              mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o);
    end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
    #1;
    vectors++;
    if (lsu_rvalid_o !== 1'b1 || if_rvalid_o !== 1'b0) begin
      miscompares++; $display("FAIL store_ack got lsu_rvalid=%b if_rvalid=%b expected 1 0", lsu_rvalid_o, if_rvalid_o);
    end
    end_rsp();
    vectors++;
    if (lsu_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin
      miscompares++; $display("FAIL store_pulse got lsu_rvalid=%b req=%b expected 0 0", lsu_rvalid_o, mem_req_o);
    end
  endtask

  task automatic test_contention();
    bit exp_lsu2;
`ifdef YSYX_23060072_ARB_RR_EN
    exp_lsu2 = 1'b0;
`else
    exp_lsu2 = 1'b1;
`endif
    // Round 1: both request, LSU wins in either mode
    if_req_i = 1'b1; if_addr_i = 32'h8000_0100;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_2000;
    #1;
    vectors++;
    if (lsu_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
      miscompares++; $display("FAIL arb_round1 got lsu=%b if=%b expected 1 0", lsu_gnt_o, if_gnt_o);
    end
    serve(1'b0, 1'b1, 32'h1111_1111);
    vectors++;
    if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== 32'h1111_1111 || if_rvalid_o !== 1'b0) begin
      miscompares++; $display("FAIL arb_route1 got lsu_rvalid=%b data=%h if_rvalid=%b expected 1 11111111 0", lsu_rvalid_o, lsu_rdata_o, if_rvalid_o);
    end
    end_rsp();
    // Round 2: new LSU request while IF is still held
    lsu_req_i = 1'b1; lsu_addr_i = 32'h8000_2004;
    #1;
    vectors++;
    if (lsu_gnt_o !== exp_lsu2 || if_gnt_o !== ~exp_lsu2) begin
      miscompares++; $display("FAIL arb_round2 got lsu=%b if=%b expected %b %b", lsu_gnt_o, if_gnt_o, exp_lsu2, ~exp_lsu2);
    end
    serve(~exp_lsu2, exp_lsu2, 32'h2222_2222);
    vectors++;
    if (lsu_rvalid_o !== exp_lsu2 || if_rvalid_o !== ~exp_lsu2) begin
      miscompares++; $display("FAIL arb_route2 got lsu_rvalid=%b if_rvalid=%b expected %b %b", lsu_rvalid_o, if_rvalid_o, exp_lsu2, ~exp_lsu2);
    end
    end_rsp();
    // Round 3: the remaining requester is served
    #1;
    vectors++;
    if (lsu_gnt_o !== ~exp_lsu2 || if_gnt_o !== exp_lsu2) begin
      miscompares++; $display("FAIL arb_round3 got lsu=%b if=%b expected %b %b", lsu_gnt_o, if_gnt_o, ~exp_lsu2, exp_lsu2);
    end
    serve(1'b1, 1'b1, 32'h3333_3333);
    vectors++;
    if (if_rvalid_o !== exp_lsu2 || lsu_rvalid_o !== ~exp_lsu2) begin
      miscompares++; $display("FAIL arb_route3 got if_rvalid=%b lsu_rvalid=%b expected %b %b", if_rvalid_o, lsu_rvalid_o, exp_lsu2, ~exp_lsu2);
    end
    end_rsp();
  endtask

  task automatic test_flush_idle();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0200; flush_i = 1'b1;
    #1;
    vectors++;
    if (if_gnt_o !== 1'b0) begin
      miscompares++; $display("FAIL flush_idle_if got gnt=%b expected 0", if_gnt_o);
    end
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_3000;
    #1;
    vectors++;
    if (lsu_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
      miscompares++; $display("FAIL flush_idle_lsu got lsu=%b if=%b expected 1 0", lsu_gnt_o, if_gnt_o);
    end
    if_req_i = 1'b0;
    tick();
    flush_i = 1'b0; lsu_req_i = 1'b0; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h4444_4444;
    end_rsp();
  endtask

  task automatic test_flush_fetch();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0008;
    tick();                                   // REQ
    if_req_i = 1'b0; mem_gnt_i = 1'b1;
    tick();                                   // WAIT, flush pulse
    mem_gnt_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    #1;
    vectors++;
    if (if_rvalid_o !== 1'b0 || lsu_rvalid_o !== 1'b0) begin
      miscompares++; $display("FAIL flush_drop got if_rvalid=%b lsu_rvalid=%b expected 0 0", if_rvalid_o, lsu_rvalid_o);
    end
    end_rsp();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0010;
    #1;
    vectors++;
    if (if_gnt_o !== 1'b1) begin
      miscompares++; $display("FAIL flush_refetch_gnt got gnt=%b expected 1", if_gnt_o);
    end
    tick();
    if_req_i = 1'b0;
    #1;
    vectors++;
    if (mem_addr_o !== 32'h8000_0010) begin
      miscompares++; $display("FAIL flush_refetch_addr got %h expected 80000010", mem_addr_o);
    end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0093;
    #1;
    vectors++;
    if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h0000_0093) begin
      miscompares++; $display("FAIL flush_refetch_rsp got rvalid=%b data=%h expected 1 00000093", if_rvalid_o, if_rdata_o);
    end
    end_rsp();
  endtask

  task automatic test_lsu_flush();
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_4000;
    tick();
    lsu_req_i = 1'b0; mem_gnt_i = 1'b1;
    tick();                                   // WAIT with flush high
    mem_gnt_i = 1'b0; flush_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    #1;
    vectors++;
    if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== 32'h1234_5678 || if_rvalid_o !== 1'b0) begin
      miscompares++; $display("FAIL lsu_flush got rvalid=%b data=%h if_rvalid=%b expected 1 12345678 0", lsu_rvalid_o, lsu_rdata_o, if_rvalid_o);
    end
    flush_i = 1'b0;
    end_rsp();
  endtask

  task automatic test_reset_mid();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0020;
    tick();
    if_req_i = 1'b0; mem_gnt_i = 1'b1;
    tick();                                   // WAIT
    mem_gnt_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || if_rvalid_o !== 1'b0 || lsu_rvalid_o !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid got req=%b addr=%h if_rvalid=%b lsu_rvalid=%b expected 0 0 0 0", mem_req_o, mem_addr_o, if_rvalid_o, lsu_rvalid_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
    #1;
    vectors++;
    if (if_rvalid_o !== 1'b0 || lsu_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin
      miscompares++; $display("FAIL rst_stale got if_rvalid=%b lsu_rvalid=%b req=%b expected 0 0 0", if_rvalid_o, lsu_rvalid_o, mem_req_o);
    end
    end_rsp();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_flush_idle();
    test_flush_fetch();
    test_lsu_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
